// File: rtl/xlr8_pkg.sv
// Shared sizing defaults and FSM encoding for the xlr8 result write-back path.
package xlr8_pkg;
    localparam int DIM    = 8;
    localparam int DW     = 16;
    localparam int AW     = 10;
    localparam int NWORDS = DIM * DIM;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FIN   = 2'd2
    } state_t;
endpackage

// File: rtl/xlr8_rise_det.sv
// Rising-edge detector for the xlr8 done level, held off for one cycle after reset
// so a done that is already high across reset release is not taken as a new job.
module xlr8_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic done,
    output logic rise
);
    logic done_q;
    logic armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            done_q <= done;
            armed  <= 1'b1;
        end
    end

    assign rise = done & ~done_q & armed;
endmodule

// File: rtl/xlr8_result_writer.sv
// Snapshots the xlr8 C matrix on done and streams it row-major to the result memory,
// one word per accepted beat, with registered address/data held stable under backpressure.
module xlr8_result_writer #(
    parameter int DIM = xlr8_pkg::DIM,
    parameter int DW  = xlr8_pkg::DW,
    parameter int AW  = xlr8_pkg::AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  done,
    input  logic [AW-1:0]         addr_mtxC,
    input  logic [DIM*DIM*DW-1:0] c_flat,
    input  logic                  mem_wr_ready,
    output logic                  mem_wr_en,
    output logic [AW-1:0]         mem_wr_addr,
    output logic [DW-1:0]         mem_wr_data,
    output logic                  busy,
    output logic                  wr_done,
    output logic                  err_overrun
);
    import xlr8_pkg::*;

    localparam int NW = DIM * DIM;
    localparam int IW = $clog2(NW);

    state_t          state, state_nx;
    logic [DW-1:0]   snap [NW];
    logic [AW-1:0]   base;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   nidx;
    logic            rise;
    logic            accept;
    logic            last;

    xlr8_rise_det u_rise_det (
        .clk  (clk),
        .rst  (rst),
        .done (done),
        .rise (rise)
    );

    assign accept = mem_wr_en & mem_wr_ready;
    assign last   = accept && (idx == IW'(NW - 1));
    assign nidx   = idx + IW'(1);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (rise) state_nx = S_WRITE;
            S_WRITE: if (last) state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Snapshot is pure data; a stale copy is never read before the next capture.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && rise && !rst) begin
            for (int i = 0; i < NW; i++) snap[i] <= c_flat[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            busy        <= 1'b0;
            wr_done     <= 1'b0;
            err_overrun <= 1'b0;
            base        <= '0;
            idx         <= '0;
        end else begin
            state   <= state_nx;
            wr_done <= 1'b0;
            if (rise && state != S_IDLE) err_overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        base        <= addr_mtxC;
                        idx         <= '0;
                        busy        <= 1'b1;
                        mem_wr_en   <= 1'b1;
                        mem_wr_addr <= addr_mtxC;
                        mem_wr_data <= c_flat[DW-1:0];
                    end
                end
                S_WRITE: begin
                    if (last) begin
                        mem_wr_en <= 1'b0;
                        wr_done   <= 1'b1;
                    end else if (accept) begin
                        idx         <= nidx;
                        mem_wr_addr <= base + AW'(nidx);
                        mem_wr_data <= snap[nidx];
                    end
                end
                S_FIN:   busy <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_xlr8_result_writer.sv
// Directed bench for xlr8_result_writer: reset, streaming, backpressure, wrap,
// overrun/snapshot isolation and mid-job reset.
module tb_xlr8_result_writer;
    logic          clk = 1'b0;
    logic          rst;
    logic          done;
    logic [9:0]    addr_mtxC;
    logic [1023:0] c_flat;
    logic          mem_wr_ready;
    logic          mem_wr_en;
    logic [9:0]    mem_wr_addr;
    logic [15:0]   mem_wr_data;
    logic          busy;
    logic          wr_done;
    logic          err_overrun;

    int n_vec = 0;
    int n_err = 0;

    xlr8_result_writer dut (
        .clk          (clk),
        .rst          (rst),
        .done         (done),
        .addr_mtxC    (addr_mtxC),
        .c_flat       (c_flat),
        .mem_wr_ready (mem_wr_ready),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .busy         (busy),
        .wr_done      (wr_done),
        .err_overrun  (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] elem(int kind, int i);
        case (kind)
            0:       return 16'(16 * (i / 8) + (i % 8));
            1:       return 16'((i / 8) * (i % 8) + 3);
            2:       return 16'(256 + i);
            default: return 16'hBEEF ^ 16'(i);
        endcase
    endfunction

    function automatic logic [1023:0] mkc(int kind);
        logic [1023:0] v;
        v = '0;
        for (int i = 0; i < 64; i++) v[i*16 +: 16] = elem(kind, i);
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1; done = 1'b1; mem_wr_ready = 1'b1; addr_mtxC = 10'd77; c_flat = mkc(0);
        tick(); tick();
        n_vec++;
        if ({mem_wr_en, mem_wr_addr, mem_wr_data, busy, wr_done, err_overrun} !== 30'd0) begin
            n_err++;
            $display("FAIL reset_outputs: en=%b addr=%0d data=%h busy=%b wr_done=%b err=%b, want all 0",
                     mem_wr_en, mem_wr_addr, mem_wr_data, busy, wr_done, err_overrun);
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_vec++;
            if (mem_wr_en !== 1'b0 || busy !== 1'b0 || wr_done !== 1'b0) begin
                n_err++;
                $display("FAIL reset_done_held cyc %0d: en=%b busy=%b wr_done=%b, want 0 0 0",
                         k, mem_wr_en, busy, wr_done);
            end
        end
        done = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        c_flat = mkc(0); addr_mtxC = 10'd128; mem_wr_ready = 1'b1;
        done = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) begin
            n_vec++;
            if (mem_wr_en !== 1'b1 || mem_wr_addr !== 10'(128 + i) || mem_wr_data !== elem(0, i) || wr_done !== 1'b0) begin
                n_err++;
                $display("FAIL basic_beat %0d: en=%b addr=%0d data=%h wr_done=%b, want 1 %0d %h 0",
                         i, mem_wr_en, mem_wr_addr, mem_wr_data, wr_done, 128 + i, elem(0, i));
            end
            tick();
        end
        n_vec++;
        if (mem_wr_en !== 1'b0 || wr_done !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_wr_done: en=%b wr_done=%b busy=%b, want 0 1 1", mem_wr_en, wr_done, busy);
        end
        tick();
        n_vec++;
        if (mem_wr_en !== 1'b0 || wr_done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_idle: en=%b wr_done=%b busy=%b, want 0 0 0", mem_wr_en, wr_done, busy);
        end
        done = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int exp_i = 0;
        int k = 0;
        c_flat = mkc(1); addr_mtxC = 10'd300; mem_wr_ready = 1'b1;
        done = 1'b1;
        tick();
        while (exp_i < 64 && k < 400) begin
            mem_wr_ready = (k % 4 == 0) || (k % 4 == 3);
            n_vec++;
            if (mem_wr_en !== 1'b1 || mem_wr_addr !== 10'(300 + exp_i) || mem_wr_data !== elem(1, exp_i) || wr_done !== 1'b0) begin
                n_err++;
                $display("FAIL bp_beat %0d cyc %0d: en=%b addr=%0d data=%h wr_done=%b, want 1 %0d %h 0",
                         exp_i, k, mem_wr_en, mem_wr_addr, mem_wr_data, wr_done, 300 + exp_i, elem(1, exp_i));
            end
            tick();
            if (mem_wr_ready) exp_i++;
            k++;
        end
        mem_wr_ready = 1'b1;
        n_vec++;
        if (k >= 400 || mem_wr_en !== 1'b0 || wr_done !== 1'b1) begin
            n_err++;
            $display("FAIL bp_wr_done: cycles=%0d en=%b wr_done=%b, want <400 0 1", k, mem_wr_en, wr_done);
        end
        done = 1'b0;
        tick(); tick();
    endtask

    task automatic test_wrap();
        c_flat = mkc(0); addr_mtxC = 10'd1000; mem_wr_ready = 1'b1;
        done = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) begin
            n_vec++;
            if (mem_wr_en !== 1'b1 || mem_wr_addr !== 10'((1000 + i) % 1024) || mem_wr_data !== elem(0, i)) begin
                n_err++;
                $display("FAIL wrap_beat %0d: en=%b addr=%0d data=%h, want 1 %0d %h",
                         i, mem_wr_en, mem_wr_addr, mem_wr_data, (1000 + i) % 1024, elem(0, i));
            end
            if (i == 24) begin
                n_vec++;
                if (mem_wr_addr !== 10'd0) begin
                    n_err++;
                    $display("FAIL wrap_idx24: addr=%0d, want 0", mem_wr_addr);
                end
            end
            tick();
        end
        n_vec++;
        if (wr_done !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_wr_done: wr_done=%b, want 1", wr_done);
        end
        done = 1'b0;
        tick(); tick();
    endtask

    task automatic test_overrun();
        n_vec++;
        if (err_overrun !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_pre: err_overrun=%b, want 0", err_overrun);
        end
        c_flat = mkc(2); addr_mtxC = 10'd0; mem_wr_ready = 1'b1;
        done = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) begin
            if (i == 10) begin c_flat = mkc(3); addr_mtxC = 10'd555; done = 1'b0; end
            if (i == 11) done = 1'b1;
            n_vec++;
            if (mem_wr_en !== 1'b1 || mem_wr_addr !== 10'(i) || mem_wr_data !== elem(2, i)) begin
                n_err++;
                $display("FAIL ovr_beat %0d: en=%b addr=%0d data=%h, want 1 %0d %h",
                         i, mem_wr_en, mem_wr_addr, mem_wr_data, i, elem(2, i));
            end
            if (i == 13) begin
                n_vec++;
                if (err_overrun !== 1'b1) begin
                    n_err++;
                    $display("FAIL ovr_flag: err_overrun=%b, want 1", err_overrun);
                end
            end
            tick();
        end
        n_vec++;
        if (wr_done !== 1'b1 || err_overrun !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_end: wr_done=%b err=%b, want 1 1", wr_done, err_overrun);
        end
        done = 1'b0;
        tick(); tick(); tick();
        n_vec++;
        if (err_overrun !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ovr_sticky: err=%b busy=%b, want 1 0", err_overrun, busy);
        end
    endtask

    task automatic test_reset_mid();
        c_flat = mkc(0); addr_mtxC = 10'd500; mem_wr_ready = 1'b1;
        done = 1'b1;
        tick();
        for (int i = 0; i <= 20; i++) begin
            n_vec++;
            if (mem_wr_en !== 1'b1 || mem_wr_addr !== 10'(500 + i) || mem_wr_data !== elem(0, i)) begin
                n_err++;
                $display("FAIL rmid_beat %0d: en=%b addr=%0d data=%h, want 1 %0d %h",
                         i, mem_wr_en, mem_wr_addr, mem_wr_data, 500 + i, elem(0, i));
            end
            if (i < 20) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (mem_wr_en !== 1'b0 || busy !== 1'b0 || wr_done !== 1'b0 || err_overrun !== 1'b0 || mem_wr_addr !== 10'd0) begin
            n_err++;
            $display("FAIL rmid_abort: en=%b busy=%b wr_done=%b err=%b addr=%0d, want 0 0 0 0 0",
                     mem_wr_en, busy, wr_done, err_overrun, mem_wr_addr);
        end
        done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (mem_wr_en !== 1'b0 || wr_done !== 1'b0) begin
                n_err++;
                $display("FAIL rmid_quiet cyc %0d: en=%b wr_done=%b, want 0 0", k, mem_wr_en, wr_done);
            end
        end
        c_flat = mkc(1); addr_mtxC = 10'd64;
        done = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) begin
            n_vec++;
            if (mem_wr_en !== 1'b1 || mem_wr_addr !== 10'(64 + i) || mem_wr_data !== elem(1, i)) begin
                n_err++;
                $display("FAIL rmid_restart %0d: en=%b addr=%0d data=%h, want 1 %0d %h",
                         i, mem_wr_en, mem_wr_addr, mem_wr_data, 64 + i, elem(1, i));
            end
            tick();
        end
        n_vec++;
        if (wr_done !== 1'b1 || mem_wr_en !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_wr_done: wr_done=%b en=%b, want 1 0", wr_done, mem_wr_en);
        end
        done = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_overrun();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
